// File: rtl/memory_cycle_if.sv
// Memory-stage bundle: M-side control/data from execute and the registered W-side
// values handed on to writeback.
interface memory_cycle_if;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;

    logic        RegWriteW;
    logic        ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;

    modport master (
        output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
        input  RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
    );

    modport slave (
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
        output RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
    );
endinterface

// File: rtl/memory_cycle.sv
// Memory pipeline stage: word-addressed data memory plus the M->W pipeline register.
// Reads return pre-write contents on a same-edge read/write collision.
module memory_cycle #(
    parameter int ADDR_BITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    memory_cycle_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] idx_p0;
    logic [31:0]          rd_data_p0;

    // Byte address low bits and bits above the array size are dropped, so addresses wrap.
    assign idx_p0     = bus.ALU_ResultM[ADDR_BITS+1:2];
    assign rd_data_p0 = mem[idx_p0];

    // Memory has no reset so its contents survive rst; writes are gated while rst is low.
    always_ff @(posedge clk) begin
        if (rst && bus.MemWriteM) begin
            mem[idx_p0] <= bus.WriteDataM;
        end
    end

    // ---- stage boundary: M -> W ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.RegWriteW   <= 1'b0;
            bus.ResultSrcW  <= 1'b0;
            bus.RD_W        <= '0;
            bus.PCPlus4W    <= '0;
            bus.ALU_ResultW <= '0;
            bus.ReadDataW   <= '0;
        end else begin
            bus.RegWriteW   <= bus.RegWriteM;
            bus.ResultSrcW  <= bus.ResultSrcM;
            bus.RD_W        <= bus.RD_M;
            bus.PCPlus4W    <= bus.PCPlus4M;
            bus.ALU_ResultW <= bus.ALU_ResultM;
            bus.ReadDataW   <= rd_data_p0;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: reset, store/load, collision, wrap, passthrough, async reset.
module tb_memory_cycle;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    memory_cycle_if bus ();

    memory_cycle #(.ADDR_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
        bus.RegWriteM   = rw;
        bus.MemWriteM   = mw;
        bus.ResultSrcM  = rs;
        bus.RD_M        = rd;
        bus.PCPlus4M    = pc;
        bus.WriteDataM  = wd;
        bus.ALU_ResultM = alu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.RegWriteW, bus.ResultSrcW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW, bus.ReadDataW} !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got RD_W=%0d PC=%h ALU=%h RD=%h required all zero",
                     bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW, bus.ReadDataW);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'hAAAA5555, 32'h10);
        step();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h10);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if ({bus.RegWriteW, bus.ResultSrcW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW, bus.ReadDataW} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got RW=%b RS=%b RD_W=%0d PC=%h ALU=%h RD=%h required all zero",
                     bus.RegWriteW, bus.ResultSrcW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW, bus.ReadDataW);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h10);
        step();
        n_checks++;
        if (bus.ReadDataW !== 32'hAAAA5555) begin
            n_fail++;
            $display("FAIL reset_mem_preserved: got %h required %h", bus.ReadDataW, 32'hAAAA5555);
        end
        n_checks++;
        if (bus.ALU_ResultW !== 32'h10) begin
            n_fail++;
            $display("FAIL reset_first_load: got %h required %h", bus.ALU_ResultW, 32'h10);
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h40);
        step();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 5'd2, 32'h8, 32'h0, 32'h40);
        step();
        n_checks++;
        if (bus.ReadDataW !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_data: got %h required %h", bus.ReadDataW, 32'hDEADBEEF);
        end
        n_checks++;
        if (bus.ResultSrcW !== 1'b1) begin
            n_fail++;
            $display("FAIL load_resultsrc: got %b required 1", bus.ResultSrcW);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h11111111, 32'h14);
        step();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h22222222, 32'h14);
        step();
        n_checks++;
        if (bus.ReadDataW !== 32'h11111111) begin
            n_fail++;
            $display("FAIL collision_old: got %h required %h", bus.ReadDataW, 32'h11111111);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h14);
        step();
        n_checks++;
        if (bus.ReadDataW !== 32'h22222222) begin
            n_fail++;
            $display("FAIL collision_new: got %h required %h", bus.ReadDataW, 32'h22222222);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h12345678, 32'h403);
        step();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h000);
        step();
        n_checks++;
        if (bus.ReadDataW !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wrap_read0: got %h required %h", bus.ReadDataW, 32'h12345678);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h002);
        step();
        n_checks++;
        if (bus.ReadDataW !== 32'h12345678) begin
            n_fail++;
            $display("FAIL align_read2: got %h required %h", bus.ReadDataW, 32'h12345678);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h4);
        step();
        n_checks++;
        if (bus.ReadDataW === 32'h12345678) begin
            n_fail++;
            $display("FAIL addr_bit2: got %h required a different word than %h", bus.ReadDataW, 32'h12345678);
        end
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd3, 32'h200, 32'h0, 32'h99);
        step();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h104, 32'h0, 32'h55);
        #1;
        n_checks++;
        if ({bus.RegWriteW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW} !== {1'b0, 5'd3, 32'h200, 32'h99}) begin
            n_fail++;
            $display("FAIL pass_before_edge: got RW=%b RD=%0d PC=%h ALU=%h required RW=0 RD=3 PC=200 ALU=99",
                     bus.RegWriteW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW);
        end
        step();
        n_checks++;
        if ({bus.RegWriteW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW} !== {1'b1, 5'd7, 32'h104, 32'h55}) begin
            n_fail++;
            $display("FAIL pass_after_edge: got RW=%b RD=%0d PC=%h ALU=%h required RW=1 RD=7 PC=104 ALU=55",
                     bus.RegWriteW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.RegWriteW, bus.ResultSrcW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW, bus.ReadDataW} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got RW=%b RD=%0d PC=%h ALU=%h required all zero",
                     bus.RegWriteW, bus.RD_W, bus.PCPlus4W, bus.ALU_ResultW);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h300, 32'h0, 32'h14);
        step();
        n_checks++;
        if ({bus.RegWriteW, bus.ResultSrcW, bus.RD_W, bus.PCPlus4W, bus.ReadDataW} !== {1'b1, 1'b1, 5'd9, 32'h300, 32'h22222222}) begin
            n_fail++;
            $display("FAIL post_reset_load: got RW=%b RS=%b RD=%0d PC=%h RD=%h required 1 1 9 300 22222222",
                     bus.RegWriteW, bus.ResultSrcW, bus.RD_W, bus.PCPlus4W, bus.ReadDataW);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        test_reset();
        test_store_load();
        test_collision();
        test_wrap();
        test_passthrough();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
